// File: rtl/m_axi_lite.sv
// -----------------------------------------------------------------------------
// m_axi_lite
//
// AXI4-Lite master that turns a simple single-outstanding command/response
// interface into AXI4-Lite read and write transactions. One transaction is in
// flight at a time; the AW and W handshakes of a write are tracked
// independently and may complete in either order or together. Saturating
// counters report completed writes, completed reads and error responses.
//
// Ports
//   M_AXI_ACLK, M_AXI_ARESETN   clock, asynchronous active-low reset
//   cmd_valid/cmd_ready          command handshake (write or read)
//   cmd_wr, cmd_addr,
//   cmd_wdata, cmd_wstrb         command payload, captured on acceptance
//   rsp_valid/rsp_ready          response handshake
//   rsp_wr, rsp_resp, rsp_rdata  response payload (rdata is 0 for writes)
//   wr_cnt, rd_cnt, err_cnt      16-bit saturating statistics
//   M_AXI_AW*, M_AXI_W*,
//   M_AXI_B*, M_AXI_AR*,
//   M_AXI_R*                     AXI4-Lite master channels
// -----------------------------------------------------------------------------
module m_axi_lite #(
  parameter int unsigned P_M_AXI_DATA_WIDTH = 32,
  parameter int unsigned P_M_AXI_ADDR_WIDTH = 4,
  parameter logic [2:0]  P_PROT             = 3'b000
) (
  input  logic                              M_AXI_ACLK,
  input  logic                              M_AXI_ARESETN,

  // Command interface
  input  logic                              cmd_valid,
  output logic                              cmd_ready,
  input  logic                              cmd_wr,
  input  logic [P_M_AXI_ADDR_WIDTH-1:0]     cmd_addr,
  input  logic [P_M_AXI_DATA_WIDTH-1:0]     cmd_wdata,
  input  logic [P_M_AXI_DATA_WIDTH/8-1:0]   cmd_wstrb,

  // Response interface
  output logic                              rsp_valid,
  input  logic                              rsp_ready,
  output logic                              rsp_wr,
  output logic [1:0]                        rsp_resp,
  output logic [P_M_AXI_DATA_WIDTH-1:0]     rsp_rdata,

  // Statistics
  output logic [15:0]                       wr_cnt,
  output logic [15:0]                       rd_cnt,
  output logic [15:0]                       err_cnt,

  // Write address channel
  output logic [P_M_AXI_ADDR_WIDTH-1:0]     M_AXI_AWADDR,
  output logic [2:0]                        M_AXI_AWPROT,
  output logic                              M_AXI_AWVALID,
  input  logic                              M_AXI_AWREADY,

  // Write data channel
  output logic [P_M_AXI_DATA_WIDTH-1:0]     M_AXI_WDATA,
  output logic [P_M_AXI_DATA_WIDTH/8-1:0]   M_AXI_WSTRB,
  output logic                              M_AXI_WVALID,
  input  logic                              M_AXI_WREADY,

  // Write response channel
  input  logic [1:0]                        M_AXI_BRESP,
  input  logic                              M_AXI_BVALID,
  output logic                              M_AXI_BREADY,

  // Read address channel
  output logic [P_M_AXI_ADDR_WIDTH-1:0]     M_AXI_ARADDR,
  output logic [2:0]                        M_AXI_ARPROT,
  output logic                              M_AXI_ARVALID,
  input  logic                              M_AXI_ARREADY,

  // Read data channel
  input  logic [P_M_AXI_DATA_WIDTH-1:0]     M_AXI_RDATA,
  input  logic [1:0]                        M_AXI_RRESP,
  input  logic                              M_AXI_RVALID,
  output logic                              M_AXI_RREADY
);

  typedef enum logic [2:0] {
    IDLE,
    WR_ADDR_DATA,
    WR_RESP,
    RD_ADDR,
    RD_DATA,
    RSP
  } state_t;

  localparam logic [1:0] RESP_OKAY = 2'b00;

  state_t state;
  logic   aw_done;
  logic   w_done;
  logic   aw_done_nxt;
  logic   w_done_nxt;

  // Protection bits are a build-time constant, so they need no register.
  assign M_AXI_AWPROT = P_PROT;
  assign M_AXI_ARPROT = P_PROT;

  // A channel counts as done if it finished earlier or is handshaking now.
  // This lets BREADY rise on the same edge that retires the last of AW/W.
  // NOTE: continuous assigns have no storage path, so no latch can be inferred
  // here; any always_comb alternative would need a default for every output.
  assign aw_done_nxt = aw_done | (M_AXI_AWVALID & M_AXI_AWREADY);
  assign w_done_nxt  = w_done  | (M_AXI_WVALID  & M_AXI_WREADY);

  function automatic logic [15:0] sat_inc(input logic [15:0] value);
    return (value == 16'hFFFF) ? value : value + 16'd1;
  endfunction

  // NOTE: every register below is written with non-blocking assignments so all
  // of them sample pre-edge values; blocking here would create order-dependent
  // behaviour between the state, flag and output updates.
  always_ff @(posedge M_AXI_ACLK or negedge M_AXI_ARESETN) begin
    if (!M_AXI_ARESETN) begin
      state         <= IDLE;
      aw_done       <= 1'b0;
      w_done        <= 1'b0;
      cmd_ready     <= 1'b0;
      rsp_valid     <= 1'b0;
      rsp_wr        <= 1'b0;
      rsp_resp      <= 2'b00;
      rsp_rdata     <= '0;
      wr_cnt        <= 16'd0;
      rd_cnt        <= 16'd0;
      err_cnt       <= 16'd0;
      M_AXI_AWADDR  <= '0;
      M_AXI_AWVALID <= 1'b0;
      M_AXI_WDATA   <= '0;
      M_AXI_WSTRB   <= '0;
      M_AXI_WVALID  <= 1'b0;
      M_AXI_BREADY  <= 1'b0;
      M_AXI_ARADDR  <= '0;
      M_AXI_ARVALID <= 1'b0;
      M_AXI_RREADY  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          // cmd_ready rises on the first edge after reset release and stays
          // high until a command is taken.
          cmd_ready <= 1'b1;
          if (cmd_valid && cmd_ready) begin
            cmd_ready <= 1'b0;
            if (cmd_wr) begin
              M_AXI_AWADDR  <= cmd_addr;
              M_AXI_WDATA   <= cmd_wdata;
              M_AXI_WSTRB   <= cmd_wstrb;
              M_AXI_AWVALID <= 1'b1;
              M_AXI_WVALID  <= 1'b1;
              aw_done       <= 1'b0;
              w_done        <= 1'b0;
              state         <= WR_ADDR_DATA;
            end else begin
              M_AXI_ARADDR  <= cmd_addr;
              M_AXI_ARVALID <= 1'b1;
              state         <= RD_ADDR;
            end
          end
        end

        WR_ADDR_DATA: begin
          if (M_AXI_AWVALID && M_AXI_AWREADY) begin
            M_AXI_AWVALID <= 1'b0;
            aw_done       <= 1'b1;
          end
          if (M_AXI_WVALID && M_AXI_WREADY) begin
            M_AXI_WVALID <= 1'b0;
            w_done       <= 1'b1;
          end
          // BREADY stays low until both halves are accepted, so an early
          // BVALID from the slave simply waits.
          if (aw_done_nxt && w_done_nxt) begin
            M_AXI_BREADY <= 1'b1;
            state        <= WR_RESP;
          end
        end

        WR_RESP: begin
          if (M_AXI_BVALID && M_AXI_BREADY) begin
            M_AXI_BREADY <= 1'b0;
            rsp_valid    <= 1'b1;
            rsp_wr       <= 1'b1;
            rsp_resp     <= M_AXI_BRESP;
            rsp_rdata    <= '0;
            wr_cnt       <= sat_inc(wr_cnt);
            if (M_AXI_BRESP != RESP_OKAY) begin
              err_cnt <= sat_inc(err_cnt);
            end
            state <= RSP;
          end
        end

        RD_ADDR: begin
          if (M_AXI_ARVALID && M_AXI_ARREADY) begin
            M_AXI_ARVALID <= 1'b0;
            M_AXI_RREADY  <= 1'b1;
            state         <= RD_DATA;
          end
        end

        RD_DATA: begin
          if (M_AXI_RVALID && M_AXI_RREADY) begin
            M_AXI_RREADY <= 1'b0;
            rsp_valid    <= 1'b1;
            rsp_wr       <= 1'b0;
            rsp_resp     <= M_AXI_RRESP;
            rsp_rdata    <= M_AXI_RDATA;
            rd_cnt       <= sat_inc(rd_cnt);
            if (M_AXI_RRESP != RESP_OKAY) begin
              err_cnt <= sat_inc(err_cnt);
            end
            state <= RSP;
          end
        end

        RSP: begin
          // Response payload is held untouched until the consumer takes it.
          if (rsp_valid && rsp_ready) begin
            rsp_valid <= 1'b0;
            cmd_ready <= 1'b1;
            state     <= IDLE;
          end
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_m_axi_lite.sv
// -----------------------------------------------------------------------------
// tb_m_axi_lite
//
// Testbench for m_axi_lite. A configurable AXI4-Lite slave model answers the
// DUT on the falling clock edge and checks channel protocol; expected responses
// are queued when a command is issued and compared when the DUT returns them.
// -----------------------------------------------------------------------------
module tb_m_axi_lite;

  localparam int DW = 32;
  localparam int AW = 4;
  localparam int SW = DW / 8;

  typedef struct {
    logic          wr;
    logic [1:0]    resp;
    logic [DW-1:0] rdata;
  } exp_t;

  logic          M_AXI_ACLK;
  logic          M_AXI_ARESETN;
  logic          cmd_valid;
  logic          cmd_ready;
  logic          cmd_wr;
  logic [AW-1:0] cmd_addr;
  logic [DW-1:0] cmd_wdata;
  logic [SW-1:0] cmd_wstrb;
  logic          rsp_valid;
  logic          rsp_ready;
  logic          rsp_wr;
  logic [1:0]    rsp_resp;
  logic [DW-1:0] rsp_rdata;
  logic [15:0]   wr_cnt;
  logic [15:0]   rd_cnt;
  logic [15:0]   err_cnt;
  logic [AW-1:0] M_AXI_AWADDR;
  logic [2:0]    M_AXI_AWPROT;
  logic          M_AXI_AWVALID;
  logic          M_AXI_AWREADY;
  logic [DW-1:0] M_AXI_WDATA;
  logic [SW-1:0] M_AXI_WSTRB;
  logic          M_AXI_WVALID;
  logic          M_AXI_WREADY;
  logic [1:0]    M_AXI_BRESP;
  logic          M_AXI_BVALID;
  logic          M_AXI_BREADY;
  logic [AW-1:0] M_AXI_ARADDR;
  logic [2:0]    M_AXI_ARPROT;
  logic          M_AXI_ARVALID;
  logic          M_AXI_ARREADY;
  logic [DW-1:0] M_AXI_RDATA;
  logic [1:0]    M_AXI_RRESP;
  logic          M_AXI_RVALID;
  logic          M_AXI_RREADY;

  m_axi_lite #(
    .P_M_AXI_DATA_WIDTH(DW),
    .P_M_AXI_ADDR_WIDTH(AW),
    .P_PROT            (3'b000)
  ) dut (
    .M_AXI_ACLK   (M_AXI_ACLK),
    .M_AXI_ARESETN(M_AXI_ARESETN),
    .cmd_valid    (cmd_valid),
    .cmd_ready    (cmd_ready),
    .cmd_wr       (cmd_wr),
    .cmd_addr     (cmd_addr),
    .cmd_wdata    (cmd_wdata),
    .cmd_wstrb    (cmd_wstrb),
    .rsp_valid    (rsp_valid),
    .rsp_ready    (rsp_ready),
    .rsp_wr       (rsp_wr),
    .rsp_resp     (rsp_resp),
    .rsp_rdata    (rsp_rdata),
    .wr_cnt       (wr_cnt),
    .rd_cnt       (rd_cnt),
    .err_cnt      (err_cnt),
    .M_AXI_AWADDR (M_AXI_AWADDR),
    .M_AXI_AWPROT (M_AXI_AWPROT),
    .M_AXI_AWVALID(M_AXI_AWVALID),
    .M_AXI_AWREADY(M_AXI_AWREADY),
    .M_AXI_WDATA  (M_AXI_WDATA),
    .M_AXI_WSTRB  (M_AXI_WSTRB),
    .M_AXI_WVALID (M_AXI_WVALID),
    .M_AXI_WREADY (M_AXI_WREADY),
    .M_AXI_BRESP  (M_AXI_BRESP),
    .M_AXI_BVALID (M_AXI_BVALID),
    .M_AXI_BREADY (M_AXI_BREADY),
    .M_AXI_ARADDR (M_AXI_ARADDR),
    .M_AXI_ARPROT (M_AXI_ARPROT),
    .M_AXI_ARVALID(M_AXI_ARVALID),
    .M_AXI_ARREADY(M_AXI_ARREADY),
    .M_AXI_RDATA  (M_AXI_RDATA),
    .M_AXI_RRESP  (M_AXI_RRESP),
    .M_AXI_RVALID (M_AXI_RVALID),
    .M_AXI_RREADY (M_AXI_RREADY)
  );

  // Bookkeeping
  int   n_checks = 0;
  int   n_fails  = 0;
  exp_t sb[$];
  int   cyc      = 0;

  // Slave configuration
  int            aw_delay  = 0;
  int            w_delay   = 0;
  int            ar_delay  = 0;
  int            r_delay   = 0;
  bit            b_early   = 1'b0;
  logic [1:0]    bresp_cfg = 2'b00;
  logic [1:0]    rresp_cfg = 2'b00;
  logic [DW-1:0] rdata_cfg = '0;

  // Expected channel payload for the command in flight
  logic [AW-1:0] exp_addr;
  logic [DW-1:0] exp_wdata;
  logic [SW-1:0] exp_wstrb;

  // Observations from the slave model
  int aw_hi, w_hi, ar_hi, n_b, n_r;
  int aw_hs_cyc, w_hs_cyc;

  initial M_AXI_ACLK = 1'b0;
  always #5 M_AXI_ACLK = ~M_AXI_ACLK;

  always @(posedge M_AXI_ACLK) cyc <= cyc + 1;

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation time limit reached before the end of test");
    $fatal(1, "watchdog expired");
  end

  // ---------------------------------------------------------------------------
  // Slave model and protocol monitor, acting on the falling edge.
  // ---------------------------------------------------------------------------
  initial begin : slave
    bit            aw_done, w_done, ar_done;
    bit            aw_fire, w_fire, ar_fire, b_fire, r_fire;
    int            aw_wait, w_wait, ar_wait, r_wait;
    logic          prev_awvalid, prev_wvalid, prev_arvalid;
    logic [AW-1:0] prev_awaddr, prev_araddr;
    logic [DW-1:0] prev_wdata;
    M_AXI_AWREADY = 1'b0;
    M_AXI_WREADY  = 1'b0;
    M_AXI_BVALID  = 1'b0;
    M_AXI_BRESP   = 2'b00;
    M_AXI_ARREADY = 1'b0;
    M_AXI_RVALID  = 1'b0;
    M_AXI_RRESP   = 2'b00;
    M_AXI_RDATA   = '0;
    forever begin
      @(negedge M_AXI_ACLK);
      if (M_AXI_ARESETN !== 1'b1) begin
        M_AXI_AWREADY = 1'b0;
        M_AXI_WREADY  = 1'b0;
        M_AXI_BVALID  = 1'b0;
        M_AXI_ARREADY = 1'b0;
        M_AXI_RVALID  = 1'b0;
        aw_done = 0; w_done = 0; ar_done = 0;
        aw_fire = 0; w_fire = 0; ar_fire = 0; b_fire = 0; r_fire = 0;
        aw_wait = 0; w_wait = 0; ar_wait = 0; r_wait = 0;
        prev_awvalid = 1'b0; prev_wvalid = 1'b0; prev_arvalid = 1'b0;
        prev_awaddr = '0; prev_araddr = '0; prev_wdata = '0;
      end else begin
        // VALID must hold, with stable payload, until its handshake.
        if (prev_awvalid && !aw_fire) begin
          n_checks++;
          if (M_AXI_AWVALID !== 1'b1 || M_AXI_AWADDR !== prev_awaddr) begin
            n_fails++;
            $display("FAIL aw_hold: AWVALID=%b AWADDR=%h, required 1/%h", M_AXI_AWVALID, M_AXI_AWADDR, prev_awaddr);
          end
        end
        if (prev_wvalid && !w_fire) begin
          n_checks++;
          if (M_AXI_WVALID !== 1'b1 || M_AXI_WDATA !== prev_wdata) begin
            n_fails++;
            $display("FAIL w_hold: WVALID=%b WDATA=%h, required 1/%h", M_AXI_WVALID, M_AXI_WDATA, prev_wdata);
          end
        end
        if (prev_arvalid && !ar_fire) begin
          n_checks++;
          if (M_AXI_ARVALID !== 1'b1 || M_AXI_ARADDR !== prev_araddr) begin
            n_fails++;
            $display("FAIL ar_hold: ARVALID=%b ARADDR=%h, required 1/%h", M_AXI_ARVALID, M_AXI_ARADDR, prev_araddr);
          end
        end

        // Retire handshakes that completed on the last rising edge.
        if (aw_fire) begin aw_done = 1; M_AXI_AWREADY = 1'b0; aw_wait = 0; aw_fire = 0; end
        if (w_fire)  begin w_done  = 1; M_AXI_WREADY  = 1'b0; w_wait  = 0; w_fire  = 0; end
        if (ar_fire) begin ar_done = 1; M_AXI_ARREADY = 1'b0; ar_wait = 0; ar_fire = 0; end
        if (b_fire) begin
          M_AXI_BVALID = 1'b0; aw_done = 0; w_done = 0; b_fire = 0; n_b++;
        end
        if (r_fire) begin
          M_AXI_RVALID = 1'b0; ar_done = 0; r_wait = 0; r_fire = 0; n_r++;
        end

        // BREADY may only appear after both AW and W have been accepted.
        if (M_AXI_BREADY === 1'b1) begin
          n_checks++;
          if (!(aw_done && w_done)) begin
            n_fails++;
            $display("FAIL bready_early: BREADY=1 with aw_done=%0d w_done=%0d, required both 1", aw_done, w_done);
          end
        end

        if (M_AXI_AWVALID === 1'b1) aw_hi++;
        if (M_AXI_WVALID  === 1'b1) w_hi++;
        if (M_AXI_ARVALID === 1'b1) ar_hi++;

        // Ready generation after the configured wait.
        if (M_AXI_AWVALID === 1'b1 && !aw_done && !M_AXI_AWREADY) begin
          if (aw_wait >= aw_delay) M_AXI_AWREADY = 1'b1; else aw_wait++;
        end
        if (M_AXI_WVALID === 1'b1 && !w_done && !M_AXI_WREADY) begin
          if (w_wait >= w_delay) M_AXI_WREADY = 1'b1; else w_wait++;
        end
        if (M_AXI_ARVALID === 1'b1 && !ar_done && !M_AXI_ARREADY) begin
          if (ar_wait >= ar_delay) M_AXI_ARREADY = 1'b1; else ar_wait++;
        end
        if (!M_AXI_BVALID && ((aw_done && w_done) || (b_early && w_done))) begin
          M_AXI_BVALID = 1'b1;
          M_AXI_BRESP  = bresp_cfg;
        end
        if (ar_done && !M_AXI_RVALID) begin
          if (r_wait >= r_delay) begin
            M_AXI_RVALID = 1'b1;
            M_AXI_RDATA  = rdata_cfg;
            M_AXI_RRESP  = rresp_cfg;
          end else begin
            r_wait++;
          end
        end

        // Handshakes that will happen on the coming rising edge.
        aw_fire = (M_AXI_AWVALID === 1'b1) && M_AXI_AWREADY;
        w_fire  = (M_AXI_WVALID  === 1'b1) && M_AXI_WREADY;
        ar_fire = (M_AXI_ARVALID === 1'b1) && M_AXI_ARREADY;
        b_fire  = M_AXI_BVALID && (M_AXI_BREADY === 1'b1);
        r_fire  = M_AXI_RVALID && (M_AXI_RREADY === 1'b1);
        if (aw_fire) begin
          aw_hs_cyc = cyc;
          n_checks++;
          if (M_AXI_AWADDR !== exp_addr || M_AXI_AWPROT !== 3'b000) begin
            n_fails++;
            $display("FAIL aw_payload: AWADDR=%h AWPROT=%b, required %h/000", M_AXI_AWADDR, M_AXI_AWPROT, exp_addr);
          end
        end
        if (w_fire) begin
          w_hs_cyc = cyc;
          n_checks++;
          if (M_AXI_WDATA !== exp_wdata || M_AXI_WSTRB !== exp_wstrb) begin
            n_fails++;
            $display("FAIL w_payload: WDATA=%h WSTRB=%h, required %h/%h", M_AXI_WDATA, M_AXI_WSTRB, exp_wdata, exp_wstrb);
          end
        end
        if (ar_fire) begin
          n_checks++;
          if (M_AXI_ARADDR !== exp_addr || M_AXI_ARPROT !== 3'b000) begin
            n_fails++;
            $display("FAIL ar_payload: ARADDR=%h ARPROT=%b, required %h/000", M_AXI_ARADDR, M_AXI_ARPROT, exp_addr);
          end
        end
        prev_awvalid = M_AXI_AWVALID; prev_awaddr = M_AXI_AWADDR;
        prev_wvalid  = M_AXI_WVALID;  prev_wdata  = M_AXI_WDATA;
        prev_arvalid = M_AXI_ARVALID; prev_araddr = M_AXI_ARADDR;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Command / response helpers
  // ---------------------------------------------------------------------------
  task automatic send_cmd(input logic wr, input logic [AW-1:0] addr,
                          input logic [DW-1:0] wdata, input logic [SW-1:0] wstrb,
                          input logic [1:0] eresp, input logic [DW-1:0] erdata);
    exp_t e;
    int   n;
    e.wr    = wr;
    e.resp  = eresp;
    e.rdata = wr ? '0 : erdata;
    sb.push_back(e);
    exp_addr  = addr;
    exp_wdata = wdata;
    exp_wstrb = wstrb;
    aw_hi = 0; w_hi = 0; ar_hi = 0; n_b = 0; n_r = 0;
    @(negedge M_AXI_ACLK);
    cmd_valid = 1'b1;
    cmd_wr    = wr;
    cmd_addr  = addr;
    cmd_wdata = wdata;
    cmd_wstrb = wstrb;
    n = 0;
    while (cmd_ready !== 1'b1 && n < 50) begin
      @(negedge M_AXI_ACLK);
      n++;
    end
    n_checks++;
    if (cmd_ready !== 1'b1) begin
      n_fails++;
      $display("FAIL cmd_accept: cmd_ready=%b after 50 cycles, required 1", cmd_ready);
      cmd_valid = 1'b0;
      return;
    end
    @(posedge M_AXI_ACLK);
    #1;
    // Scramble the payload so a late capture would be visible.
    cmd_valid = 1'b0;
    cmd_wr    = ~wr;
    cmd_addr  = ~addr;
    cmd_wdata = ~wdata;
    cmd_wstrb = '0;
  endtask

  task automatic get_rsp(input int hold);
    exp_t e;
    int   n;
    @(negedge M_AXI_ACLK);
    n = 0;
    while (rsp_valid !== 1'b1 && n < 200) begin
      @(negedge M_AXI_ACLK);
      n++;
    end
    n_checks++;
    if (rsp_valid !== 1'b1) begin
      n_fails++;
      $display("FAIL rsp_timeout: rsp_valid=%b after 200 cycles, required 1", rsp_valid);
      return;
    end
    n_checks++;
    if (sb.size() == 0) begin
      n_fails++;
      $display("FAIL rsp_unexpected: response with empty scoreboard, required none");
      return;
    end
    e = sb.pop_front();
    n_checks++;
    if (rsp_wr !== e.wr || rsp_resp !== e.resp || rsp_rdata !== e.rdata) begin
      n_fails++;
      $display("FAIL rsp_payload: wr=%b resp=%b rdata=%h, required %b/%b/%h",
               rsp_wr, rsp_resp, rsp_rdata, e.wr, e.resp, e.rdata);
    end
    for (int i = 0; i < hold; i++) begin
      @(negedge M_AXI_ACLK);
      n_checks++;
      if (rsp_valid !== 1'b1 || rsp_rdata !== e.rdata || rsp_resp !== e.resp || cmd_ready !== 1'b0) begin
        n_fails++;
        $display("FAIL rsp_hold: cycle %0d valid=%b rdata=%h resp=%b cmd_ready=%b, required 1/%h/%b/0",
                 i, rsp_valid, rsp_rdata, rsp_resp, cmd_ready, e.rdata, e.resp);
      end
    end
    rsp_ready = 1'b1;
    @(negedge M_AXI_ACLK);
    rsp_ready = 1'b0;
    n_checks++;
    if (rsp_valid !== 1'b0 || cmd_ready !== 1'b1) begin
      n_fails++;
      $display("FAIL rsp_release: rsp_valid=%b cmd_ready=%b, required 0/1", rsp_valid, cmd_ready);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Scenarios
  // ---------------------------------------------------------------------------
  task automatic test_reset();
    M_AXI_ARESETN = 1'b0;
    cmd_valid = 1'b0; cmd_wr = 1'b0; cmd_addr = '0; cmd_wdata = '0; cmd_wstrb = '0;
    rsp_ready = 1'b0;
    repeat (3) @(negedge M_AXI_ACLK);
    n_checks++;
    if ({cmd_ready, rsp_valid, M_AXI_AWVALID, M_AXI_WVALID, M_AXI_BREADY, M_AXI_ARVALID, M_AXI_RREADY} !== 7'b0 ||
        {wr_cnt, rd_cnt, err_cnt} !== 48'h0 || M_AXI_AWADDR !== '0 || M_AXI_WDATA !== '0 ||
        rsp_rdata !== '0 || rsp_resp !== 2'b00) begin
      n_fails++;
      $display("FAIL reset_values: cmd_ready=%b rsp_valid=%b awv=%b wv=%b br=%b arv=%b rr=%b cnt=%h/%h/%h, required all 0",
               cmd_ready, rsp_valid, M_AXI_AWVALID, M_AXI_WVALID, M_AXI_BREADY, M_AXI_ARVALID, M_AXI_RREADY,
               wr_cnt, rd_cnt, err_cnt);
    end
    M_AXI_ARESETN = 1'b1;
    @(negedge M_AXI_ACLK);
    n_checks++;
    if (cmd_ready !== 1'b1) begin
      n_fails++;
      $display("FAIL reset_release: cmd_ready=%b one cycle after release, required 1", cmd_ready);
    end
  endtask

  task automatic test_write_basic();
    send_cmd(1'b1, 4'h4, 32'hDEADBEEF, 4'hF, 2'b00, '0);
    get_rsp(0);
    n_checks++;
    if (aw_hi != 1 || w_hi != 1 || n_b != 1 || wr_cnt !== 16'd1) begin
      n_fails++;
      $display("FAIL write_basic: aw_cycles=%0d w_cycles=%0d b_count=%0d wr_cnt=%0d, required 1/1/1/1",
               aw_hi, w_hi, n_b, wr_cnt);
    end
  endtask

  task automatic test_skewed_write();
    aw_delay = 3;
    b_early  = 1'b1;
    send_cmd(1'b1, 4'hC, 32'hA5A55A5A, 4'h3, 2'b00, '0);
    get_rsp(0);
    n_checks++;
    if (aw_hs_cyc - w_hs_cyc != 3 || aw_hi != 4 || w_hi != 1) begin
      n_fails++;
      $display("FAIL skew_order: aw-w gap=%0d aw_cycles=%0d w_cycles=%0d, required 3/4/1",
               aw_hs_cyc - w_hs_cyc, aw_hi, w_hi);
    end
    repeat (3) @(negedge M_AXI_ACLK);
    n_checks++;
    if (n_b != 1 || rsp_valid !== 1'b0 || sb.size() != 0 || wr_cnt !== 16'd2) begin
      n_fails++;
      $display("FAIL skew_single: b_count=%0d rsp_valid=%b pending=%0d wr_cnt=%0d, required 1/0/0/2",
               n_b, rsp_valid, sb.size(), wr_cnt);
    end
    aw_delay = 0;
    b_early  = 1'b0;
  endtask

  task automatic test_read_stall();
    r_delay   = 2;
    rdata_cfg = 32'h12345678;
    send_cmd(1'b0, 4'h8, '0, '0, 2'b00, 32'h12345678);
    get_rsp(5);
    n_checks++;
    if (rd_cnt !== 16'd1 || ar_hi != 1 || n_r != 1) begin
      n_fails++;
      $display("FAIL read_stall: rd_cnt=%0d ar_cycles=%0d r_count=%0d, required 1/1/1", rd_cnt, ar_hi, n_r);
    end
    r_delay = 0;
  endtask

  task automatic test_errors();
    rresp_cfg = 2'b10;
    rdata_cfg = 32'hCAFEF00D;
    send_cmd(1'b0, 4'h2, '0, '0, 2'b10, 32'hCAFEF00D);
    get_rsp(0);
    bresp_cfg = 2'b11;
    send_cmd(1'b1, 4'h6, 32'h0000_1111, 4'h1, 2'b11, '0);
    get_rsp(0);
    n_checks++;
    if (err_cnt !== 16'd2 || rd_cnt !== 16'd2 || wr_cnt !== 16'd3) begin
      n_fails++;
      $display("FAIL error_counts: err=%0d rd=%0d wr=%0d, required 2/2/3", err_cnt, rd_cnt, wr_cnt);
    end
    rresp_cfg = 2'b00;
    bresp_cfg = 2'b00;
  endtask

  task automatic test_back_to_back();
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    for (int i = 0; i < 4; i++) begin
      a = AW'($urandom_range(0, 15));
      d = $urandom;
      if (i % 2 == 0) begin
        send_cmd(1'b1, a, d, SW'($urandom_range(0, 15)), 2'b00, '0);
      end else begin
        rdata_cfg = d;
        send_cmd(1'b0, a, '0, '0, 2'b00, d);
      end
      get_rsp(i);
    end
    n_checks++;
    if (wr_cnt !== 16'd5 || rd_cnt !== 16'd4 || err_cnt !== 16'd2) begin
      n_fails++;
      $display("FAIL b2b_counts: wr=%0d rd=%0d err=%0d, required 5/4/2", wr_cnt, rd_cnt, err_cnt);
    end
  endtask

  task automatic test_saturation();
    @(negedge M_AXI_ACLK);
    force dut.wr_cnt = 16'hFFFE;
    @(negedge M_AXI_ACLK);
    release dut.wr_cnt;
    @(negedge M_AXI_ACLK);
    n_checks++;
    if (wr_cnt !== 16'hFFFE) begin
      n_fails++;
      $display("FAIL sat_preload: wr_cnt=%h, required fffe", wr_cnt);
    end
    send_cmd(1'b1, 4'h1, 32'h1, 4'h1, 2'b00, '0);
    get_rsp(0);
    n_checks++;
    if (wr_cnt !== 16'hFFFF) begin
      n_fails++;
      $display("FAIL sat_reach: wr_cnt=%h, required ffff", wr_cnt);
    end
    send_cmd(1'b1, 4'h2, 32'h2, 4'h2, 2'b00, '0);
    get_rsp(0);
    n_checks++;
    if (wr_cnt !== 16'hFFFF || err_cnt !== 16'd2) begin
      n_fails++;
      $display("FAIL sat_hold: wr_cnt=%h err_cnt=%0d, required ffff/2", wr_cnt, err_cnt);
    end
  endtask

  task automatic test_reset_mid();
    aw_delay = 50;
    w_delay  = 50;
    send_cmd(1'b1, 4'hA, 32'h55AA55AA, 4'hF, 2'b00, '0);
    @(negedge M_AXI_ACLK);
    n_checks++;
    if (M_AXI_AWVALID !== 1'b1) begin
      n_fails++;
      $display("FAIL midrst_pre: AWVALID=%b, required 1", M_AXI_AWVALID);
    end
    #2;
    M_AXI_ARESETN = 1'b0;
    #1;
    n_checks++;
    if ({cmd_ready, rsp_valid, M_AXI_AWVALID, M_AXI_WVALID, M_AXI_BREADY, M_AXI_ARVALID, M_AXI_RREADY} !== 7'b0 ||
        {wr_cnt, rd_cnt, err_cnt} !== 48'h0) begin
      n_fails++;
      $display("FAIL midrst_async: ready/valid=%b cnt=%h/%h/%h, required all 0",
               {cmd_ready, rsp_valid, M_AXI_AWVALID, M_AXI_WVALID, M_AXI_BREADY, M_AXI_ARVALID, M_AXI_RREADY},
               wr_cnt, rd_cnt, err_cnt);
    end
    sb.delete();
    aw_delay = 0;
    w_delay  = 0;
    repeat (2) @(negedge M_AXI_ACLK);
    M_AXI_ARESETN = 1'b1;
    @(negedge M_AXI_ACLK);
    n_checks++;
    if (cmd_ready !== 1'b1 || rsp_valid !== 1'b0) begin
      n_fails++;
      $display("FAIL midrst_release: cmd_ready=%b rsp_valid=%b, required 1/0", cmd_ready, rsp_valid);
    end
    rdata_cfg = 32'h0BADF00D;
    send_cmd(1'b0, 4'h0, '0, '0, 2'b00, 32'h0BADF00D);
    get_rsp(0);
    n_checks++;
    if (rd_cnt !== 16'd1 || wr_cnt !== 16'd0 || err_cnt !== 16'd0) begin
      n_fails++;
      $display("FAIL midrst_after: rd=%0d wr=%0d err=%0d, required 1/0/0", rd_cnt, wr_cnt, err_cnt);
    end
  endtask

  initial begin : main
    test_reset();
    test_write_basic();
    test_skewed_write();
    test_read_stall();
    test_errors();
    test_back_to_back();
    test_saturation();
    test_reset_mid();
    repeat (2) @(negedge M_AXI_ACLK);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
